router_pkt_tx: RTL and testbench

ROUTER_PKT_TX -- requirements
Module: router_pkt_tx

---
 rtl/router_pkg.sv | 20 ++
 rtl/router_pkt_tx_buffer.sv | 23 ++
 rtl/router_pkt_tx.sv | 124 ++++++++++++
 tb/tb_router_pkt_tx.sv | 263 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/router_pkg.sv
// Shared types, limits and the header packing helper for the router packet transmitter.
package router_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_HEADER,
    S_PAYLOAD,
    S_PARITY,
    S_GAP
  } state_t;

  localparam int         MAX_LEN      = 63;
  localparam logic [1:0] ADDR_INVALID = 2'b11;

  function automatic logic [7:0] hdr_pack(input logic [5:0] len, input logic [1:0] addr);
    return {len, addr};
  endfunction

endpackage

// File: rtl/router_pkt_tx_buffer.sv
// Payload store: one synchronous write port, one asynchronous read port.
module tx_buffer #(
  parameter  int DEPTH = 64,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic          clock,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [7:0]    wdata,
  input  logic [AW-1:0] raddr,
  output logic [7:0]    rdata
);

  logic [7:0] mem [DEPTH];

  // NOTE: the array has no reset; every byte read was written earlier in the same packet.
  always_ff @(posedge clock) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/router_pkt_tx.sv
// Buffers one packet's payload, then sends header, payload and parity to the router,
// honouring suspend_data, followed by a fixed idle gap.
module router_pkt_tx
  import router_pkg::*;
#(
  parameter int GAP_CYCLES = 1
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       req_valid,
  input  logic [1:0] req_addr,
  input  logic [5:0] req_len,
  output logic       req_ready,
  input  logic [7:0] pl_data,
  input  logic       pl_valid,
  output logic       pl_ready,
  input  logic       suspend_data,
  output logic [7:0] data,
  output logic       packet_valid,
  output logic       tx_busy,
  output logic       pkt_done,
  output logic       req_err
);

  localparam logic [3:0] GAP_LAST = 4'(GAP_CYCLES - 1);

  state_t     state, state_d;
  logic [5:0] idx, len, rd_addr;
  logic [1:0] addr;
  logic [7:0] parity, rd_data, data_d, data_q;
  logic [3:0] gap_cnt;
  logic       pv_d, pv_q, req_err_q;
  logic       req_take, req_bad, byte_take, last_idx;

  assign req_take  = req_valid && req_ready;
  assign req_bad   = (req_len == 6'd0) || (req_addr == ADDR_INVALID);
  assign byte_take = pl_valid && pl_ready;
  assign last_idx  = idx == len - 6'd1;

  tx_buffer #(.DEPTH(MAX_LEN + 1)) u_buf (
    .clock (clock),
    .we    (byte_take),
    .waddr (idx),
    .wdata (pl_data),
    .raddr (rd_addr),
    .rdata (rd_data)
  );

  // NOTE: sequential state uses <= so every register samples pre-edge values.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) state <= S_IDLE;
    else       state <= state_d;
  end

  // NOTE: each comb output gets a default first, so no path leaves it unassigned (no latch).
  always_comb begin
    state_d = state;
    unique case (state)
      S_IDLE:    if (req_take && !req_bad) state_d = S_LOAD;
      S_LOAD:    if (byte_take && last_idx) state_d = S_HEADER;
      S_HEADER:  if (!suspend_data) state_d = S_PAYLOAD;
      S_PAYLOAD: if (!suspend_data && last_idx) state_d = S_PARITY;
      S_PARITY:  if (!suspend_data) state_d = S_GAP;
      S_GAP:     if (gap_cnt == GAP_LAST) state_d = S_IDLE;
      default:   state_d = S_IDLE;
    endcase
  end

  // The byte bus is decoded from the next state and registered, so a suspended
  // cycle (state and idx frozen) reproduces the same value.
  always_comb begin
    req_ready = (state == S_IDLE) && !reset;
    pl_ready  = state == S_LOAD;
    tx_busy   = state != S_IDLE;
    pkt_done  = (state == S_PARITY) && !suspend_data;
    rd_addr   = (state == S_PAYLOAD && !suspend_data) ? idx + 6'd1 : idx;
    data_d    = 8'h00;
    pv_d      = 1'b0;
    case (state_d)
      S_HEADER:  begin data_d = hdr_pack(len, addr); pv_d = 1'b1; end
      S_PAYLOAD: begin data_d = rd_data;             pv_d = 1'b1; end
      S_PARITY:  data_d = parity;
      default:   ;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      idx       <= '0;
      len       <= '0;
      addr      <= '0;
      parity    <= '0;
      gap_cnt   <= '0;
      data_q    <= '0;
      pv_q      <= 1'b0;
      req_err_q <= 1'b0;
    end else begin
      data_q    <= data_d;
      pv_q      <= pv_d;
      req_err_q <= req_take && req_bad;
      case (state)
        S_IDLE: if (req_take && !req_bad) begin
          len    <= req_len;
          addr   <= req_addr;
          idx    <= '0;
          parity <= hdr_pack(req_len, req_addr);
        end
        S_LOAD: if (byte_take) begin
          parity <= parity ^ pl_data;
          idx    <= last_idx ? 6'd0 : idx + 6'd1;
        end
        S_PAYLOAD: if (!suspend_data) idx <= idx + 6'd1;
        S_PARITY:  gap_cnt <= '0;
        S_GAP:     gap_cnt <= gap_cnt + 4'd1;
        default:   ;
      endcase
    end
  end

  assign data         = data_q;
  assign packet_valid = pv_q;
  assign req_err      = req_err_q;

endmodule

// File: tb/tb_router_pkt_tx.sv
// Randomised and directed bench for router_pkt_tx with a queue-based packet model.
module tb_router_pkt_tx;

  localparam int GAP = 1;

  logic       clock = 1'b0, reset = 1'b1;
  logic       req_valid = 1'b0, pl_valid = 1'b0, suspend_data = 1'b0;
  logic [1:0] req_addr = '0;
  logic [5:0] req_len = '0;
  logic [7:0] pl_data = '0;
  logic       req_ready, pl_ready, packet_valid, tx_busy, pkt_done, req_err;
  logic [7:0] data;

  router_pkt_tx #(.GAP_CYCLES(GAP)) dut (
    .clock(clock), .reset(reset), .req_valid(req_valid), .req_addr(req_addr),
    .req_len(req_len), .req_ready(req_ready), .pl_data(pl_data), .pl_valid(pl_valid),
    .pl_ready(pl_ready), .suspend_data(suspend_data), .data(data),
    .packet_valid(packet_valid), .tx_busy(tx_busy), .pkt_done(pkt_done), .req_err(req_err)
  );

  always #5 clock = ~clock;

  int checks = 0, failures = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Model: bytes still to load, queue of {packet_valid,data} still to send, gap cycles left.
  logic [8:0] tx_q[$];
  logic [7:0] pl_q[$];
  int         m_load_left = 0, m_gap_left = 0;
  logic       m_err = 1'b0, m_idle;
  logic [5:0] m_len = '0;
  logic [1:0] m_addr = '0;
  logic [8:0] m_head;
  logic [7:0] m_par;

  int         done_cnt = 0, err_cnt = 0, busy_cnt = 0, pv_cnt = 0, hold22 = 0;
  int         last_gap = -1, gap_run = 0;
  logic       gap_on = 1'b0, prev_pv = 1'b0;
  logic [7:0] last_parity = '0, last_header = '0;

  always @(negedge clock) begin
    if (reset) begin
      check("rst_data", 32'(data), 32'h0);
      check("rst_packet_valid", 32'(packet_valid), 32'h0);
      check("rst_req_ready", 32'(req_ready), 32'h0);
      check("rst_pl_ready", 32'(pl_ready), 32'h0);
      check("rst_tx_busy", 32'(tx_busy), 32'h0);
      check("rst_pkt_done", 32'(pkt_done), 32'h0);
      check("rst_req_err", 32'(req_err), 32'h0);
      tx_q.delete(); pl_q.delete();
      m_load_left = 0; m_gap_left = 0; m_err = 1'b0; gap_on = 1'b0; prev_pv = 1'b0;
    end else begin
      m_idle = (m_load_left == 0) && (tx_q.size() == 0) && (m_gap_left == 0);
      m_head = (tx_q.size() != 0) ? tx_q[0] : 9'h000;
      check("data", 32'(data), 32'(m_head[7:0]));
      check("packet_valid", 32'(packet_valid), 32'(m_head[8]));
      check("req_ready", 32'(req_ready), 32'(m_idle));
      check("pl_ready", 32'(pl_ready), 32'(m_load_left > 0));
      check("tx_busy", 32'(tx_busy), 32'(!m_idle));
      check("pkt_done", 32'(pkt_done), 32'(tx_q.size() == 1 && !suspend_data));
      check("req_err", 32'(req_err), 32'(m_err));

      if (pkt_done) begin
        done_cnt++; last_parity = data; gap_on = 1'b1; gap_run = 0;
      end else if (gap_on) begin
        if (req_ready) begin last_gap = gap_run; gap_on = 1'b0; end
        else gap_run++;
      end
      if (req_err) err_cnt++;
      if (tx_busy) busy_cnt++;
      if (packet_valid) pv_cnt++;
      if (packet_valid && data == 8'h22) hold22++;
      if (packet_valid && !prev_pv) last_header = data;
      prev_pv = packet_valid;

      m_err = m_idle && req_valid && (req_len == 6'd0 || req_addr == 2'd3);
      if (m_idle) begin
        if (req_valid && req_len != 6'd0 && req_addr != 2'd3) begin
          m_len = req_len; m_addr = req_addr; m_load_left = int'(req_len); pl_q.delete();
        end
      end else if (m_load_left > 0) begin
        if (pl_valid) begin
          pl_q.push_back(pl_data);
          m_load_left--;
          if (m_load_left == 0) begin
            m_par = 8'(int'(m_len) * 4 + int'(m_addr));
            tx_q.push_back({1'b1, m_par});
            foreach (pl_q[i]) begin
              tx_q.push_back({1'b1, pl_q[i]});
              m_par = m_par ^ pl_q[i];
            end
            tx_q.push_back({1'b0, m_par});
          end
        end
      end else if (tx_q.size() != 0) begin
        if (!suspend_data) begin
          m_head = tx_q.pop_front();
          if (tx_q.size() == 0) m_gap_left = GAP;
        end
      end else begin
        m_gap_left--;
      end
    end
  end

  bit rand_susp = 1'b0, rand_noise = 1'b0;

  task automatic tick();
    @(posedge clock);
    #1;
    if (rand_susp) suspend_data = ($urandom_range(0, 3) == 0);
    if (rand_noise) begin
      req_valid = !req_ready && ($urandom_range(0, 3) == 0);
      req_addr  = 2'($urandom);
      req_len   = 6'($urandom);
    end
  endtask

  task automatic send_req(input logic [1:0] a, input logic [5:0] l);
    int n = 0;
    while (!req_ready && n < 3000) begin tick(); n++; end
    check("wait_req_ready", 32'(req_ready), 32'h1);
    req_valid = 1'b1; req_addr = a; req_len = l;
    tick();
    req_valid = 1'b0;
  endtask

  task automatic load(input int l, input bit bubbles, input int base, input int step, input bit rnd);
    int   k = 0, n = 0;
    logic take;
    while (k < l && n < 3000) begin
      pl_valid = !(bubbles && $urandom_range(0, 2) == 0);
      pl_data  = rnd ? 8'($urandom) : 8'(base + step * k);
      take     = pl_valid && pl_ready;
      tick(); n++;
      if (take) k++;
    end
    pl_valid = 1'b0;
    check("load_bytes_taken", 32'(k), 32'(l));
  endtask

  task automatic wait_idle();
    int n = 0;
    while (!req_ready && n < 3000) begin tick(); n++; end
    check("wait_idle", 32'(req_ready), 32'h1);
    tick();
  endtask

  int d0, e0, b0, p0, n;
  int la;
  int ll;

  initial begin
    tick(); tick();
    reset = 1'b0;
    tick();

    // Basic packet: header 0D, 11 22 33, parity 0D.
    send_req(2'd1, 6'd3);
    load(3, 1'b0, 'h11, 'h11, 1'b0);
    wait_idle();
    check("basic_header", 32'(last_header), 32'h0D);
    check("basic_parity", 32'(last_parity), 32'h0D);
    check("basic_done_count", 32'(done_cnt), 32'd1);
    check("basic_gap_cycles", 32'(last_gap), 32'(GAP));

    // Same packet with byte 22 suspended for two cycles.
    hold22 = 0; p0 = pv_cnt;
    send_req(2'd1, 6'd3);
    load(3, 1'b0, 'h11, 'h11, 1'b0);
    n = 0;
    while (!(packet_valid && data == 8'h22) && n < 50) begin tick(); n++; end
    suspend_data = 1'b1;
    tick(); tick();
    suspend_data = 1'b0;
    wait_idle();
    check("suspend_hold22_cycles", 32'(hold22), 32'd3);
    check("suspend_pv_cycles", 32'(pv_cnt - p0), 32'd6);
    check("suspend_parity", 32'(last_parity), 32'h0D);

    // Two rejected requests: no transmission, no busy cycles.
    e0 = err_cnt; b0 = busy_cnt; d0 = done_cnt;
    send_req(2'd1, 6'd0);
    send_req(2'd3, 6'd5);
    tick(); tick();
    check("reject_err_pulses", 32'(err_cnt - e0), 32'd2);
    check("reject_busy_cycles", 32'(busy_cnt - b0), 32'd0);
    check("reject_no_done", 32'(done_cnt - d0), 32'd0);

    // Maximum length: header FE, parity FE ^ (00..3E) = C1.
    p0 = pv_cnt;
    send_req(2'd2, 6'd63);
    load(63, 1'b0, 0, 1, 1'b0);
    wait_idle();
    check("max_header", 32'(last_header), 32'hFE);
    check("max_parity", 32'(last_parity), 32'hC1);
    check("max_pv_cycles", 32'(pv_cnt - p0), 32'd64);

    // Reset during payload, then a fresh packet: header 08, 05 0A, parity 07.
    d0 = done_cnt;
    send_req(2'd0, 6'd10);
    load(10, 1'b0, 'h40, 1, 1'b0);
    n = 0;
    while (!(packet_valid && data == 8'h42) && n < 50) begin tick(); n++; end
    reset = 1'b1;
    #1;
    check("rst_mid_packet_valid", 32'(packet_valid), 32'h0);
    check("rst_mid_data", 32'(data), 32'h0);
    tick();
    reset = 1'b0;
    check("rst_mid_no_done", 32'(done_cnt - d0), 32'd0);
    send_req(2'd0, 6'd2);
    load(2, 1'b0, 5, 5, 1'b0);
    wait_idle();
    check("after_rst_header", 32'(last_header), 32'h08);
    check("after_rst_parity", 32'(last_parity), 32'h07);

    // Back-to-back packets, first one minimal length.
    d0 = done_cnt; p0 = pv_cnt;
    send_req(2'd1, 6'd1);
    load(1, 1'b0, 'hA5, 0, 1'b0);
    send_req(2'd2, 6'd2);
    load(2, 1'b0, 1, 1, 1'b0);
    wait_idle();
    check("b2b_done_count", 32'(done_cnt - d0), 32'd2);
    check("b2b_pv_cycles", 32'(pv_cnt - p0), 32'd5);
    check("b2b_gap_cycles", 32'(last_gap), 32'(GAP));

    // Random traffic with suspend, bubbles and ignored requests while busy.
    rand_susp = 1'b1; rand_noise = 1'b1;
    for (int i = 0; i < 40; i++) begin
      la = $urandom_range(0, 3);
      ll = ($urandom_range(0, 7) == 0) ? 0 : (($urandom_range(0, 9) == 0) ? 63 : $urandom_range(1, 20));
      send_req(2'(la), 6'(ll));
      if (la != 3 && ll != 0) load(ll, 1'b1, 0, 0, 1'b1);
      else tick();
      if ($urandom_range(0, 1) == 0) wait_idle();
    end
    wait_idle();
    rand_susp = 1'b0; rand_noise = 1'b0;
    suspend_data = 1'b0; req_valid = 1'b0;
    tick(); tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #600000;
    failures++;
    $display("FAIL watchdog: simulation still running at %0t, expected completion", $time);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
